// File: rtl/ahb_mtx_pkg.sv
// rtl/ahb_mtx_pkg.sv - shared AHB matrix types, constants and burst length helper
// Contents:
//   htrans_e  : HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ)
//   hburst_e  : HBURST encodings (SINGLE .. INCR16)
//   ARB_FIXED / ARB_RR : arbitration mode selectors
//   burst_len : number of beats minus one for a given HBURST
package ahb_mtx_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Undefined-length INCR reports a single beat so it is never held.
    function automatic logic [3:0] burst_len(input logic [2:0] hburst);
        logic [3:0] len_m1;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  len_m1 = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  len_m1 = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: len_m1 = 4'd15;
            default:                      len_m1 = 4'd0;
        endcase
        return len_m1;
    endfunction

endpackage

// File: rtl/ahb_mtx_arb_param_if.sv
// rtl/ahb_mtx_arb_param_if.sv - output-port arbitration bus between input stages and arbiter
// Signals:
//   req_port[NUM_PORTS]  per-port request
//   HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM  output-port AHB control
//   addr_in_port[PORT_W], no_port  registered grant to the output mux
//   burst_hold  combinational debug view of the burst-hold condition
// Modports: master drives requests/control, slave is the arbiter.
interface ahb_mtx_arb_param_if #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 3
);
    logic [NUM_PORTS-1:0] req_port;
    logic                 HREADYM;
    logic                 HSELM;
    logic [1:0]           HTRANSM;
    logic [2:0]           HBURSTM;
    logic                 HMASTLOCKM;
    logic [PORT_W-1:0]    addr_in_port;
    logic                 no_port;
    logic                 burst_hold;

    modport master (
        output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        input  addr_in_port, no_port, burst_hold
    );

    modport slave (
        input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        output addr_in_port, no_port, burst_hold
    );
endinterface

// File: rtl/ahb_mtx_rr_pick.sv
// rtl/ahb_mtx_rr_pick.sv - combinational fixed/rotating priority picker
// Ports:
//   req[NUM_PORTS]  candidate requests
//   ptr[IDX_W]      last winner; rotating search starts just above it
//   mode            0 = lowest index wins, 1 = rotate from ptr+1
//   winner[IDX_W]   selected index (0 when none)
//   valid           at least one request present
module ahb_mtx_rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    input  logic                 mode,
    output logic [IDX_W-1:0]     winner,
    output logic                 valid
);

    // k-th index in search order; ptr itself comes last in rotating mode.
    function automatic logic [IDX_W-1:0] order_idx(input logic m,
                                                   input logic [IDX_W-1:0] p,
                                                   input int k);
        int idx;
        idx = m ? (int'(p) + 1 + k) % NUM_PORTS : k;
        return IDX_W'(idx);
    endfunction

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!valid && req[order_idx(mode, ptr, k)]) begin
                winner = order_idx(mode, ptr, k);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_mtx_arb_param.sv
// rtl/ahb_mtx_arb_param.sv - output-stage arbiter with burst-aware grant holding
// Ports:
//   HCLK     AHB clock
//   HRESETn  asynchronous active-low reset
//   bus      slave modport: requests and output-port control in,
//            addr_in_port/no_port (registered) and burst_hold (comb) out
module ahb_mtx_arb_param
    import ahb_mtx_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int PORT_W     = 3,
    parameter int PORT_BASE  = 0,
    parameter int ARB_MODE   = ARB_FIXED,
    parameter int BURST_HOLD = 1
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    ahb_mtx_arb_param_if.slave bus
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PORT_W-1:0]    addr_q;
    logic                 no_port_q;
    logic [3:0]           beat_cnt;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     winner;
    logic                 win_valid;
    logic [NUM_PORTS-1:0] eff_req;
    logic [3:0]           len_m1;
    logic                 hold_c;
    logic                 cur_active;

    assign len_m1 = burst_len(bus.HBURSTM);

    // The granted port keeps competing while it drives a live transfer,
    // even if its request line has already dropped.
    assign cur_active = ~no_port_q & bus.HSELM & (bus.HTRANSM != HTRANS_IDLE);

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_eff
        assign eff_req[i] = bus.req_port[i] |
                            (cur_active & (addr_q == PORT_W'(PORT_BASE + i)));
    end

    // At the last SEQ beat (beat_cnt == 1) the hold is released so the next
    // address phase can already belong to another port.
    always_comb begin
        hold_c = 1'b0;
        if ((BURST_HOLD != 0) && !no_port_q && bus.HSELM) begin
            case (bus.HTRANSM)
                HTRANS_NONSEQ: hold_c = (len_m1 != 4'd0);
                HTRANS_SEQ:    hold_c = (beat_cnt > 4'd1);
                HTRANS_BUSY:   hold_c = (beat_cnt != 4'd0);
                default:       hold_c = 1'b0;
            endcase
        end
    end

    ahb_mtx_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req    (eff_req),
        .ptr    (rr_ptr),
        .mode   (ARB_MODE == ARB_RR),
        .winner (winner),
        .valid  (win_valid)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q    <= PORT_W'(PORT_BASE);
            no_port_q <= 1'b1;
            beat_cnt  <= 4'd0;
            rr_ptr    <= '0;
        end else if (bus.HREADYM) begin
            if (!bus.HSELM || (bus.HTRANSM == HTRANS_IDLE)) begin
                beat_cnt <= 4'd0;
            end else if (bus.HTRANSM == HTRANS_NONSEQ) begin
                beat_cnt <= len_m1;
            end else if ((bus.HTRANSM == HTRANS_SEQ) && (beat_cnt != 4'd0)) begin
                beat_cnt <= beat_cnt - 4'd1;
            end

            // Lock and burst hold both freeze the grant.
            if (!bus.HMASTLOCKM && !hold_c) begin
                if (win_valid) begin
                    addr_q    <= PORT_W'(PORT_BASE) + PORT_W'(winner);
                    no_port_q <= 1'b0;
                    rr_ptr    <= winner;
                end else if (bus.HSELM) begin
                    no_port_q <= 1'b0;
                end else begin
                    no_port_q <= 1'b1;
                end
            end
        end
    end

    assign bus.addr_in_port = addr_q;
    assign bus.no_port      = no_port_q;
    assign bus.burst_hold   = hold_c;

endmodule

// File: doc/ahb_mtx_arb_param.md
Name: ahb_mtx_arb_param

Overview:
Parametrised output-stage arbiter for the AHB bus matrix. It selects which of NUM_PORTS input stages drives a shared slave (master) port. It supports fixed-priority or round-robin arbitration, plus burst-aware grant holding for fixed-length bursts. It sits between the input stages and the output-stage address/data mux, which it drives with addr_in_port and no_port.

Parameters:
NUM_PORTS, 4, number of input ports arbitrated (2..8)
PORT_W, 3, width of addr_in_port; must satisfy 2**PORT_W >= PORT_BASE+NUM_PORTS
PORT_BASE, 0, port number reported for req_port[0]; port i reports PORT_BASE+i
ARB_MODE, 0, 0 = fixed priority (index 0 highest), 1 = round-robin
BURST_HOLD, 1, 1 = hold grant for the whole of INCR4/8/16 and WRAP4/8/16 bursts

Ports:
HCLK  input  1  AHB clock
HRESETn  input  1  async active-low reset
req_port  input  NUM_PORTS  per-port request
HREADYM  input  1  output-port transfer done
HSELM  input  1  slave select on output port
HTRANSM  input  2  transfer type
HBURSTM  input  3  burst type
HMASTLOCKM  input  1  locked transfer
addr_in_port  output  PORT_W  granted port number (registered)
no_port  output  1  no port selected (registered)
burst_hold  output  1  burst-hold condition active this cycle (combinational, debug)

Behaviour:
- Reset: HRESETn is asynchronous, active-low; clock is HCLK. On reset: no_port=1, addr_in_port=PORT_BASE, beat_cnt=0, rr_ptr=0.
- All registers update only on posedge HCLK with HREADYM=1. With HREADYM=0, every register holds.
- cur = addr_in_port - PORT_BASE.
- beat_cnt (4 bits) counts remaining beats of the granted port's burst:
  - HSELM & HTRANSM=NONSEQ: load len-1, where len is 1 for SINGLE/INCR, 4 for INCR4/WRAP4, 8 for INCR8/WRAP8, 16 for INCR16/WRAP16.
  - HSELM & SEQ & beat_cnt!=0: decrement.
  - BUSY: hold.
  - IDLE, or HSELM=0: clear (early termination).
- burst_hold = BURST_HOLD & ~no_port & HSELM & any of:
  - NONSEQ with len>1
  - SEQ with beat_cnt>1
  - BUSY with beat_cnt!=0
- Undefined-length INCR is never held. It may be pre-empted at any beat.
- Next-state priority (first match wins):
  1. HMASTLOCKM=1: hold addr_in_port and no_port.
  2. burst_hold=1: hold.
  3. Form eff_req[i] = req_port[i] | (i==cur & ~no_port & HSELM & HTRANSM!=IDLE).
     - ARB_MODE=0: lowest set index wins.
     - ARB_MODE=1: search from rr_ptr+1 upward, wrapping modulo NUM_PORTS; rr_ptr itself is checked last.
     - Winner: addr_in_port=PORT_BASE+winner, no_port=0.
  4. No eff_req set and HSELM=1: hold addr_in_port; no_port=0.
  5. Otherwise: no_port=1; addr_in_port holds.
- rr_ptr loads the winner index whenever rule 3 grants. It is unused when ARB_MODE=0.
- Latency: grant is visible one HREADYM-qualified cycle after the request.
- Simultaneous events:
  - Lock beats burst_hold.
  - At the last beat of a burst (SEQ, beat_cnt=1), the arbiter is released, so a competing request is granted for the next address phase.
- Reset mid-burst: all state returns to reset values immediately.

Decomposition:
- Shared package ahb_mtx_pkg holds:
  - HTRANS constants: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
  - HBURST constants: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
  - ARB_FIXED=0, ARB_RR=1.
  - Function burst_len(hburst) returning 4-bit len-1.
- One sub-module: ahb_mtx_rr_pick. It is a combinational rotate-priority picker taking req, ptr and mode, and returning winner and valid. It is instantiated once.

Test Plan:
- Reset then idle: HRESETn=0 -> no_port=1, addr_in_port=PORT_BASE; release with req_port=0, HSELM=0 -> no_port stays 1.
- Fixed priority: ARB_MODE=0, req_port=4'b1010, HREADYM=1 -> next cycle addr_in_port=1; then req_port=4'b1000 with port-1 IDLE -> addr_in_port=3.
- Round-robin: ARB_MODE=1, req_port=4'b1111 held, single transfers -> grants cycle 1,2,3,0,1.
- Burst hold: port 2 issues INCR4 (NONSEQ + 3 SEQ, HREADYM=1) while port 0 requests -> addr_in_port=2 for all 4 beats, then 0 on the next address phase. Insert 2 HREADYM=0 wait cycles mid-burst -> grant is unchanged.
- Lock and early termination:
  - HMASTLOCKM=1 on port 3 with req_port[0]=1 -> addr_in_port stays 3 until lock drops.
  - INCR8 aborted by IDLE after beat 3 -> beat_cnt=0 and port 0 is granted next cycle.
